// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller: opcodes,
// forwarding select encodings, FSM states and the per-stage shadow entry.
package hazard_pkg;

    localparam logic [3:0] OP_LW = 4'h8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] dst;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       wr;
        logic       ld;
    } entry_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX source operand. The EX/MEM path wins over
// MEM/WB, and a load still in MEM has no data yet, so it never forwards.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [3:0] src_i,
    input  logic       mem_valid_i,
    input  logic       mem_wr_i,
    input  logic       mem_ld_i,
    input  logic [3:0] mem_dst_i,
    input  logic       wb_valid_i,
    input  logic       wb_wr_i,
    input  logic [3:0] wb_dst_i,
    output logic [1:0] sel_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid_i & mem_wr_i & ~mem_ld_i & (mem_dst_i == src_i);
    assign wb_hit  = wb_valid_i & wb_wr_i & (wb_dst_i == src_i);

    assign sel_o = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush bubbles,
// EX forwarding selects from a shadow copy of EX/MEM/WB tags, stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             id_regwrite,
    input  logic             id_rt_used,
    input  logic             flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             st,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    entry_t           ex_q, ex_d, mem_q, wb_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz;
    logic             stall_w;

    logic [3:0] id_op, id_dst, id_rs, id_rt;
    assign id_op  = id_instr[31:28];
    assign id_dst = id_instr[27:24];
    assign id_rs  = id_instr[23:20];
    assign id_rt  = id_instr[19:16];

    // The LSTALL guard bounds a single load to one stall cycle even if EX were held.
    assign hz = id_valid & ex_q.valid & ex_q.ld & ex_q.wr & (state_q != LSTALL)
              & ((ex_q.dst == id_rs) | (id_rt_used & (ex_q.dst == id_rt)));

    assign stall_w    = hz & ~flush;
    assign stall      = stall_w;
    assign st         = hz | flush;
    assign pc_write   = ~stall_w;
    assign ifid_write = ~stall_w;
    assign stall_cnt  = cnt_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ex_d    = '0;
        state_d = RUN;
        cnt_d   = cnt_q;
        if (id_valid && !stall_w && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.dst   = id_dst;
            ex_d.rs    = id_rs;
            ex_d.rt    = id_rt;
            ex_d.wr    = id_regwrite;
            ex_d.ld    = (id_op == OP_LW);
        end
        if (flush) begin
            state_d = FLUSH;
        end else if (hz) begin
            state_d = LSTALL;
        end
        if (stall_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_sel u_fwd_a (
        .src_i      (ex_q.rs),
        .mem_valid_i(mem_q.valid),
        .mem_wr_i   (mem_q.wr),
        .mem_ld_i   (mem_q.ld),
        .mem_dst_i  (mem_q.dst),
        .wb_valid_i (wb_q.valid),
        .wb_wr_i    (wb_q.wr),
        .wb_dst_i   (wb_q.dst),
        .sel_o      (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_i      (ex_q.rt),
        .mem_valid_i(mem_q.valid),
        .mem_wr_i   (mem_q.wr),
        .mem_ld_i   (mem_q.ld),
        .mem_dst_i  (mem_q.dst),
        .wb_valid_i (wb_q.valid),
        .wb_wr_i    (wb_q.wr),
        .wb_dst_i   (wb_q.dst),
        .sel_o      (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected
// outputs, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_regwrite;
    logic        id_rt_used;
    logic        flush;
    logic        pc_write;
    logic        ifid_write;
    logic        st;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic [3:0]  stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_regwrite(id_regwrite),
        .id_rt_used (id_rt_used),
        .flush      (flush),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .st         (st),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic       chk_fwd;
        logic       stall;
        logic       st;
        logic       pcw;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s, input logic [3:0] t);
        return {op, d, s, t, 16'h0000};
    endfunction

    function automatic exp_t ex(input logic stl, input logic s, input logic pcw,
                                input logic chk, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [3:0] cnt);
        exp_t e;
        e.stall = stl; e.st = s; e.pcw = pcw; e.chk_fwd = chk;
        e.fa = fa; e.fb = fb; e.cnt = cnt;
        return e;
    endfunction

    task automatic bump();
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rw,
                         input logic rtu, input logic fl, input logic r, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_instr = ins; id_regwrite = rw;
        id_rt_used = rtu; flush = fl;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (stall !== e.stall) begin
                n_bad++; $display("FAIL stall @%0t: got %b want %b", $time, stall, e.stall);
            end
            n_vec++;
            if (st !== e.st) begin
                n_bad++; $display("FAIL st @%0t: got %b want %b", $time, st, e.st);
            end
            n_vec++;
            if (pc_write !== e.pcw || ifid_write !== e.pcw) begin
                n_bad++;
                $display("FAIL pc_write/ifid_write @%0t: got %b/%b want %b", $time, pc_write, ifid_write, e.pcw);
            end
            n_vec++;
            if (stall_cnt !== e.cnt) begin
                n_bad++; $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.cnt);
            end
            if (e.chk_fwd) begin
                n_vec++;
                if (fwd_a !== e.fa) begin
                    n_bad++; $display("FAIL fwd_a @%0t: got %b want %b", $time, fwd_a, e.fa);
                end
                n_vec++;
                if (fwd_b !== e.fb) begin
                    n_bad++; $display("FAIL fwd_b @%0t: got %b want %b", $time, fwd_b, e.fb);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_instr = $urandom; id_regwrite = 1'($urandom);
            id_rt_used = 1'($urandom); flush = 1'($urandom);
            @(posedge clk);
        end
        #1;
        rst = 1'b0; id_valid = 1'b0; id_instr = 32'h0; id_regwrite = 1'b0;
        id_rt_used = 1'b0; flush = 1'b0;
        exp_cnt = 4'd0;
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt); end
        n_vec++;
        if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            n_bad++; $display("FAIL reset pc_write/ifid_write: got %b/%b want 1", pc_write, ifid_write);
        end
        n_vec++;
        if (st !== 1'b0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL reset st/stall: got %b/%b want 0/0", st, stall);
        end
        n_vec++;
        if (fwd_a !== FWD_RF || fwd_b !== FWD_RF) begin
            n_bad++; $display("FAIL reset fwd: got %b/%b want 00/00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_load_use();
        drive(1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1, 0, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 0, 0, ex(1, 1, 0, 0, FWD_RF, FWD_RF, exp_cnt));
        bump();
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(0, 32'h0, 0, 0, 0, 0, ex(0, 0, 1, 1, FWD_WB, FWD_RF, exp_cnt));
    endtask

    task automatic test_back_to_back();
        idle(3);
        drive(1, mk(4'h0, 4'd2, 4'd1, 4'd1), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h1, 4'd7, 4'd8, 4'd2), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(0, 32'h0, 0, 0, 0, 0, ex(0, 0, 1, 1, FWD_RF, FWD_MEM, exp_cnt));
        idle(3);
        drive(1, mk(4'h0, 4'd2, 4'd1, 4'd1), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd9, 4'd10, 4'd11), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h1, 4'd7, 4'd8, 4'd2), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(0, 32'h0, 0, 0, 0, 0, ex(0, 0, 1, 1, FWD_RF, FWD_WB, exp_cnt));
    endtask

    task automatic test_mem_wins();
        idle(3);
        drive(1, mk(4'h0, 4'd6, 4'd1, 4'd1), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd6, 4'd1, 4'd1), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h2, 4'd7, 4'd6, 4'd0), 1, 0, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(0, 32'h0, 0, 0, 0, 0, ex(0, 0, 1, 1, FWD_MEM, FWD_RF, exp_cnt));
    endtask

    task automatic test_flush();
        idle(3);
        drive(1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1, 0, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 1, 0, ex(0, 1, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        idle(1);
    endtask

    task automatic test_saturate_and_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1, 0, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
            drive(1, mk(4'h0, 4'd5, 4'd4, 4'd3), 1, 1, 0, 0, ex(1, 1, 0, 0, FWD_RF, FWD_RF, exp_cnt));
            bump();
            drive(1, mk(4'h0, 4'd5, 4'd4, 4'd3), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        end
        idle(1);
        drive(1, mk(OP_LW, 4'd3, 4'd0, 4'd0), 1, 0, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 0, 1, ex(1, 1, 0, 0, FWD_RF, FWD_RF, exp_cnt));
        exp_cnt = 4'd0;
        drive(1, mk(4'h0, 4'd5, 4'd3, 4'd4), 1, 1, 0, 0, ex(0, 0, 1, 0, FWD_RF, FWD_RF, exp_cnt));
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; id_regwrite = 1'b0;
        id_rt_used = 1'b0; flush = 1'b0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_wins();
        test_flush();
        test_saturate_and_reset();
        @(posedge clk);
        @(posedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
